// File: rtl/csa_pkg.sv
// csa_pkg: adder geometry and accumulator FSM states shared by the adder, its consumers and benches
package csa_pkg;
  localparam int CSA_SUM_W = 29;
  localparam int CSA_ADD_LAT = 2;
  typedef enum logic {S_IDLE, S_ACC} state_e;
endpackage

// File: rtl/valid_delay_line.sv
// valid_delay_line: shift register that realigns a valid bit with a fixed-latency datapath
module valid_delay_line #(
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             flush,
  input  logic             in_valid,
  output logic             tap,
  output logic [DEPTH-1:0] line
);
  logic [DEPTH-1:0] line_q, line_d;
  always_comb begin
    line_d = flush ? '0 : DEPTH'({line_q, in_valid});
  end
  always_ff @(posedge clk) begin
    if (!rstn) line_q <= '0;
    else line_q <= line_d;
  end
  assign tap = line_q[DEPTH-1];
  assign line = line_q;
endmodule

// File: rtl/csa_sum_block_accum.sv
// csa_sum_block_accum: sums BLOCK_LEN aligned adder outputs into saturating totals behind a one-entry valid/ready register
module csa_sum_block_accum
  import csa_pkg::*;
#(
  parameter int SUM_W = CSA_SUM_W,
  parameter int ADD_LAT = CSA_ADD_LAT,
  parameter int BLOCK_LEN = 4,
  parameter int ACC_W = 36
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             clr,
  input  logic             in_valid,
  input  logic [SUM_W-1:0] sum_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_total,
  output logic             out_sat,
  output logic             ovf_err,
  output logic             busy
);
  localparam int CW = $clog2(BLOCK_LEN + 1);
  logic               tap;
  logic [ADD_LAT-1:0] line;
  state_e             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [ACC_W-1:0]   acc_q, acc_d, tot_q, tot_d, base, sum_tot;
  logic [ACC_W:0]     wide;
  logic               sat_q, sat_d, ov_q, ov_d, osat_q, osat_d, err_q, err_d;
  logic               v, last, done, pop, load, sum_sat;
  valid_delay_line #(.DEPTH(ADD_LAT)) u_dl (
    .clk(clk), .rstn(rstn), .flush(clr), .in_valid(in_valid), .tap(tap), .line(line)
  );
  always_comb begin
    v       = tap & ~clr;
    last    = int'(cnt_q) + 1 == BLOCK_LEN;
    done    = v & last;
    base    = state_q == S_ACC ? acc_q : '0;
    wide    = {1'b0, base} + (ACC_W+1)'(sum_in);
    sum_tot = wide[ACC_W] ? '1 : wide[ACC_W-1:0];
    sum_sat = wide[ACC_W] | (state_q == S_ACC & sat_q);
    state_d = clr | done ? S_IDLE : v ? S_ACC : state_q;
    cnt_d   = clr | done ? '0 : v ? cnt_q + CW'(1) : cnt_q;
    acc_d   = clr | done ? '0 : v ? sum_tot : acc_q;
    sat_d   = clr | done ? 1'b0 : v ? sum_sat : sat_q;
    pop     = ov_q & out_ready;
    load    = done & (~ov_q | pop);
    ov_d    = load | (ov_q & ~pop);
    tot_d   = load ? sum_tot : tot_q;
    osat_d  = load ? sum_sat : osat_q;
    err_d   = ~clr & (err_q | (done & ~load));
  end
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      acc_q   <= '0;
      sat_q   <= 1'b0;
      ov_q    <= 1'b0;
      tot_q   <= '0;
      osat_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      sat_q   <= sat_d;
      ov_q    <= ov_d;
      tot_q   <= tot_d;
      osat_q  <= osat_d;
      err_q   <= err_d;
    end
  end
  assign out_valid = ov_q;
  assign out_total = tot_q;
  assign out_sat   = osat_q;
  assign ovf_err   = err_q;
  assign busy      = (state_q == S_ACC) | (|line);
endmodule

// File: tb/tb_csa_sum_block_accum.sv
// tb_csa_sum_block_accum: directed scoreboard bench with a behavioural two-cycle adder in front of the accumulator
module tb_csa_sum_block_accum;
  logic        clk = 0, rstn = 0, clr = 0, in_valid = 0, in_valid_s = 0, out_ready = 1, sel_s = 0;
  logic        out_ready_s = 1;
  logic [28:0] op = '0, p1 = '0, p2 = '0;
  logic        out_valid, out_sat, ovf_err, busy;
  logic [35:0] out_total;
  logic        sv, ss, se, sb;
  logic [29:0] st;
  int          total = 0, bad = 0;
  typedef struct {logic [35:0] t; logic s;} exp_t;
  exp_t q[$], qs[$];

  always #5 clk = ~clk;
  always @(posedge clk) begin
    p1 <= op;
    p2 <= p1;
  end

  csa_sum_block_accum dut (
    .clk(clk), .rstn(rstn), .clr(clr), .in_valid(in_valid), .sum_in(p2),
    .out_valid(out_valid), .out_ready(out_ready), .out_total(out_total),
    .out_sat(out_sat), .ovf_err(ovf_err), .busy(busy)
  );
  csa_sum_block_accum #(.BLOCK_LEN(3), .ACC_W(30)) dut_s (
    .clk(clk), .rstn(rstn), .clr(clr), .in_valid(in_valid_s), .sum_in(p2),
    .out_valid(sv), .out_ready(out_ready_s), .out_total(st),
    .out_sat(ss), .ovf_err(se), .busy(sb)
  );

  task automatic chk(input string n, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", n, act, exp, $time);
    end
  endtask

  task automatic cyc(input logic v, input logic [28:0] val);
    in_valid   = v & ~sel_s;
    in_valid_s = v & sel_s;
    op = v ? val : 29'($urandom);
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [35:0] t, input logic s);
    exp_t e;
    e.t = t;
    e.s = s;
    q.push_back(e);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (rstn && out_valid && out_ready) begin
      if (q.size() == 0) chk("unexpected_total", 1, 0);
      else begin
        e = q.pop_front();
        chk("out_total", 64'(out_total), 64'(e.t));
        chk("out_sat", 64'(out_sat), 64'(e.s));
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (rstn && sv && out_ready_s) begin
      if (qs.size() == 0) chk("unexpected_sat_total", 1, 0);
      else begin
        e = qs.pop_front();
        chk("sat_total", 64'(st), 64'(e.t));
        chk("sat_flag", 64'(ss), 64'(e.s));
      end
    end
  end

  initial begin
    exp_t e;
    repeat (2) cyc(0, 0);
    chk("rst_valid", 64'(out_valid), 0);
    chk("rst_total", 64'(out_total), 0);
    chk("rst_sat", 64'(out_sat), 0);
    chk("rst_ovf", 64'(ovf_err), 0);
    chk("rst_busy", 64'(busy), 0);
    rstn = 1;
    // basic block 1+2+3+4
    push(36'hA, 0);
    cyc(1, 1); cyc(1, 2); cyc(1, 3); cyc(1, 4);
    cyc(0, 0);
    chk("lat_early", 64'(out_valid), 0);
    cyc(0, 0);
    chk("lat_valid", 64'(out_valid), 1);
    repeat (3) cyc(0, 0);
    chk("idle_busy", 64'(busy), 0);
    // bubbles with garbage between valid sums
    push(36'h20000014, 0);
    cyc(1, 29'h1FFFFFFF); cyc(0, 0); cyc(0, 0); cyc(1, 5); cyc(0, 0);
    cyc(1, 7); cyc(0, 0); cyc(0, 0); cyc(0, 0); cyc(1, 9);
    repeat (4) cyc(0, 0);
    // saturation on the narrow instance
    sel_s = 1;
    e.t = 36'h3FFFFFFF;
    e.s = 1;
    qs.push_back(e);
    repeat (3) cyc(1, 29'h1FFFFFFF);
    repeat (4) cyc(0, 0);
    sel_s = 0;
    // backpressure: second block dropped
    out_ready = 0;
    repeat (4) cyc(1, 1);
    repeat (4) cyc(1, 2);
    repeat (4) cyc(0, 0);
    chk("bp_valid", 64'(out_valid), 1);
    chk("bp_total", 64'(out_total), 4);
    chk("bp_ovf", 64'(ovf_err), 1);
    push(36'd4, 0);
    out_ready = 1;
    cyc(0, 0);
    push(36'd12, 0);
    repeat (4) cyc(1, 3);
    repeat (4) cyc(0, 0);
    chk("bp_ovf_sticky", 64'(ovf_err), 1);
    clr = 1;
    cyc(0, 0);
    clr = 0;
    chk("clr_ovf", 64'(ovf_err), 0);
    // pop and completion on the same edge
    out_ready = 0;
    push(36'd20, 0);
    repeat (4) cyc(1, 5);
    repeat (4) cyc(0, 0);
    push(36'd40, 0);
    repeat (4) cyc(1, 10);
    cyc(0, 0);
    out_ready = 1;
    cyc(0, 0);
    out_ready = 0;
    chk("pc_valid", 64'(out_valid), 1);
    chk("pc_total", 64'(out_total), 40);
    chk("pc_ovf", 64'(ovf_err), 0);
    out_ready = 1;
    repeat (3) cyc(0, 0);
    // reset mid-block
    cyc(1, 7); cyc(1, 7);
    rstn = 0;
    cyc(0, 0);
    rstn = 1;
    chk("rst_mid_busy", 64'(busy), 0);
    chk("rst_mid_valid", 64'(out_valid), 0);
    push(36'd100, 0);
    cyc(1, 10); cyc(1, 20); cyc(1, 30); cyc(1, 40);
    repeat (4) cyc(0, 0);
    // clr mid-block
    cyc(1, 7); cyc(1, 7);
    clr = 1;
    cyc(0, 0);
    clr = 0;
    chk("clr_mid_busy", 64'(busy), 0);
    push(36'd100, 0);
    cyc(1, 10); cyc(1, 20); cyc(1, 30); cyc(1, 40);
    repeat (5) cyc(0, 0);
    chk("queue_drained", 64'(q.size()), 0);
    chk("sat_queue_drained", 64'(qs.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
